// File: rtl/immgen_pipe_if.sv
// rtl/immgen_pipe_if.sv - handshake bundle between decode and the immediate generator
interface immgen_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [2:0]            out_fmt;
  logic                  out_illegal;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output flush, in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - pipelined RISC-V immediate generator with 2-entry skid buffer
module immgen_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  immgen_pipe_if.slave bus
);
  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  // Every format fits a 32-bit signed value; widen by replicating bit 31.
  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
    logic [DATA_WIDTH-1:0] r;
    r       = {DATA_WIDTH{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [31:0]           inst;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] d_imm;
  logic [2:0]            d_fmt;
  logic                  d_ill;

  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_imm;
  logic [2:0]            main_fmt;
  logic                  main_ill;
  logic [TAG_WIDTH-1:0]  main_tag;

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_imm;
  logic [2:0]            skid_fmt;
  logic                  skid_ill;
  logic [TAG_WIDTH-1:0]  skid_tag;

  logic                  accept;
  logic                  main_open;

  assign inst      = bus.in_inst;
  assign accept    = bus.in_valid && bus.in_ready;
  // Main can take new data when empty or when its current entry leaves this cycle.
  assign main_open = !main_valid || (main_valid && bus.out_ready);

  // Decode the incoming instruction into a 32-bit immediate, format and illegal flag.
  always_comb begin
    imm32 = '0;
    d_fmt = FMT_NONE;
    d_ill = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        d_fmt = FMT_I;
      end
      7'b0010011: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          // funct7 shares these bits but is never part of the shift amount.
          if (DATA_WIDTH == 64) imm32 = {26'b0, inst[25:20]};
          else                  imm32 = {27'b0, inst[24:20]};
          d_fmt = FMT_SHAMT;
        end else begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
          d_fmt = FMT_I;
        end
      end
      7'b0100011: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d_fmt = FMT_S;
      end
      7'b1100011: begin
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        d_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32 = {inst[31:12], 12'b0};
        d_fmt = FMT_U;
      end
      7'b1101111: begin
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d_fmt = FMT_J;
      end
      default: d_ill = 1'b1;
    endcase
    d_imm = sext32(imm32);
  end

  // Main entry: refilled from skid first so ordering stays FIFO, else from the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_fmt   <= '0;
      main_ill   <= 1'b0;
      main_tag   <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
    end else if (main_open) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        main_ill   <= skid_ill;
        main_tag   <= skid_tag;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_imm <= d_imm;
          main_fmt <= d_fmt;
          main_ill <= d_ill;
          main_tag <= bus.in_tag;
        end
      end
    end
  end

  // Skid entry: catches a transfer that arrives while main is held by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= '0;
      skid_ill   <= 1'b0;
      skid_tag   <= '0;
    end else if (bus.flush) begin
      skid_valid <= 1'b0;
    end else if (main_open && skid_valid) begin
      skid_valid <= 1'b0;
    end else if (!main_open && accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= d_imm;
      skid_fmt   <= d_fmt;
      skid_ill   <= d_ill;
      skid_tag   <= bus.in_tag;
    end
  end

  // Outputs come straight from the main entry registers.
  assign bus.in_ready    = !rst && !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_illegal = main_ill;
  assign bus.out_tag     = main_tag;
endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - scoreboard bench for immgen_pipe at 32- and 64-bit widths
module tb_immgen_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t exp_q[$];
  vec_t vt[18];

  always #5 clk = ~clk;

  immgen_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(32)) b32();
  immgen_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(32)) b64();

  assign b32.flush     = flush;
  assign b32.in_valid  = in_valid;
  assign b32.in_inst   = in_inst;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.flush     = flush;
  assign b64.in_valid  = in_valid;
  assign b64.in_inst   = in_inst;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  immgen_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  immgen_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // Monitor: every transfer on the output must match the oldest expected entry.
  always @(negedge clk) begin
    vec_t e;
    if (!rst && b32.out_valid && b32.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got tag %h expected no output", b32.out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("imm32", {32'b0, b32.out_imm}, {32'b0, e.imm32});
        chk("fmt32", {61'b0, b32.out_fmt}, {61'b0, e.fmt});
        chk("ill32", {63'b0, b32.out_illegal}, {63'b0, e.ill});
        chk("tag32", {32'b0, b32.out_tag}, {32'b0, e.tag});
        chk("valid64", {63'b0, b64.out_valid}, 64'd1);
        chk("imm64", b64.out_imm, e.imm64);
        chk("tag64", {32'b0, b64.out_tag}, {32'b0, e.tag});
      end
    end
  end

  task automatic wait_accept(input vec_t v, input logic do_flush);
    int n = 0;
    while (!b32.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else if (!do_flush) begin
      exp_q.push_back(v);
    end
  endtask

  task automatic send(input vec_t v, input logic do_flush);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_tag   = v.tag;
    flush    = do_flush;
    wait_accept(v, do_flush);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vt[1]  = '{32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vt[2]  = '{32'hFF9FF06F, 32'h108, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0};
    vt[3]  = '{32'h12345037, 32'h10C, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0};
    vt[4]  = '{32'h01F09093, 32'h110, 32'h0000001F, 64'h000000000000001F, 3'd6, 1'b0};
    vt[5]  = '{32'h4030D093, 32'h114, 32'h00000003, 64'h0000000000000003, 3'd6, 1'b0};
    vt[6]  = '{32'h0000007F, 32'h118, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1};
    vt[7]  = '{32'h02009093, 32'h11C, 32'h00000000, 64'h0000000000000020, 3'd6, 1'b0};
    vt[8]  = '{32'h0020A423, 32'h120, 32'h00000008, 64'h0000000000000008, 3'd2, 1'b0};
    vt[9]  = '{32'hFE20AE23, 32'h124, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vt[10] = '{32'h80000017, 32'h128, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vt[11] = '{32'h7FF02083, 32'h12C, 32'h000007FF, 64'h00000000000007FF, 3'd1, 1'b0};
    vt[12] = '{32'h00000073, 32'h130, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0};
    vt[13] = '{32'h0FF0000F, 32'h134, 32'h000000FF, 64'h00000000000000FF, 3'd1, 1'b0};
    vt[14] = '{32'h00008067, 32'h138, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0};
    vt[15] = '{32'h002081B3, 32'h13C, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1};
    vt[16] = '{32'h0010006F, 32'h140, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0};
    vt[17] = '{32'h00001863, 32'h144, 32'h00000010, 64'h0000000000000010, 3'd3, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'b0, b32.in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("rst_out_imm", {32'b0, b32.out_imm}, 64'd0);
    chk("rst_out_fmt", {61'b0, b32.out_fmt}, 64'd0);
    chk("rst_out_tag", {32'b0, b32.out_tag}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'b0, b32.in_ready}, 64'd1);

    // Full-rate stream of every vector with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send(vt[i], 1'b0);
    idle();
    drain_all();

    // Stall: A into main, B into skid, C must wait until the consumer returns.
    out_ready = 1'b0;
    send(vt[0], 1'b0);
    send(vt[3], 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = vt[5].inst; in_tag = vt[5].tag;
    chk("stall_in_ready", {63'b0, b32.in_ready}, 64'd0);
    chk("stall_out_tag", {32'b0, b32.out_tag}, {32'b0, vt[0].tag});
    @(posedge clk); #1;
    chk("stall_hold_imm", {32'b0, b32.out_imm}, {32'b0, vt[0].imm32});
    chk("stall_hold_valid", {63'b0, b32.out_valid}, 64'd1);
    out_ready = 1'b1;
    wait_accept(vt[5], 1'b0);
    idle();
    drain_all();

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    send(vt[1], 1'b0);
    send(vt[2], 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = vt[6].inst; in_tag = vt[6].tag; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, b32.in_ready}, 64'd1);

    // Flush while in_ready is high: the offered input must be discarded.
    send(vt[8], 1'b0);
    send(vt[9], 1'b1);
    idle();
    exp_q.delete();
    chk("flush2_out_valid", {63'b0, b32.out_valid}, 64'd0);
    out_ready = 1'b1;
    send(vt[10], 1'b0);
    idle();
    drain_all();

    // Reset in the middle of buffered traffic.
    out_ready = 1'b0;
    send(vt[11], 1'b0);
    send(vt[4], 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("midrst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("midrst_out_imm", {32'b0, b32.out_imm}, 64'd0);
    chk("midrst_out_fmt", {61'b0, b32.out_fmt}, 64'd0);
    chk("midrst_out_ill", {63'b0, b32.out_illegal}, 64'd0);
    chk("midrst_out_tag", {32'b0, b32.out_tag}, 64'd0);
    chk("midrst_imm64", b64.out_imm, 64'd0);
    chk("midrst_in_ready", {63'b0, b32.in_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", {63'b0, b32.in_ready}, 64'd1);
    out_ready = 1'b1;
    send(vt[13], 1'b0);
    idle();
    drain_all();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Pipelined, handshaked immediate generator for all base RISC-V instruction formats (I, S, B, U, J, plus shift-amount), parametrised in data width and sideband tag. It sits between fetch/decode and register read. Each accepted instruction yields a sign-extended immediate, a format code and an illegal-opcode flag, one cycle later, through a 2-entry skid buffer. Pipeline flush discards all in-flight entries.

## Interface
Parameters:
- DATA_WIDTH, 32, immediate output width; legal values 32 or 64.
- TAG_WIDTH, 32, width of opaque sideband (e.g. PC) carried with each instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_WIDTH  sideband, returned unmodified.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  DATA_WIDTH  extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_WIDTH  sideband of the result.

## Operation
- Decode on in_inst[6:0]:
  - LOAD 0000011, MISC-MEM 0001111, JALR 1100111, SYSTEM 1110011: I, sign-extend inst[31:20].
  - OP-IMM 0010011: I, except funct3 001/101, which is SHAMT. SHAMT zero-extends inst[24:20] when DATA_WIDTH=32 and inst[25:20] when 64. funct7 is never part of the value.
  - STORE 0100011: S, sign-extend {inst[31:25], inst[11:7]}.
  - BRANCH 1100011: B, sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - LUI 0110111, AUIPC 0010111: U, sign-extend {inst[31:12], 12'b0}.
  - JAL 1101111: J, sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Any other opcode: fmt NONE, imm 0, illegal 1.
- Sign extension replicates the top source bit up to DATA_WIDTH.
- Decode is combinational on the input side and registered into the main entry. Outputs always come from registers.
- Storage has two entries:
  - Main drives out_*.
  - Skid absorbs one transfer made while main is stalled.
- Accept condition: in_valid && in_ready. in_ready = !rst && !skid_valid.
- Main entry update:
  - Main empty, or main drained this cycle (out_valid && out_ready): accepted data loads main. If skid is valid, skid moves to main first and accepted data goes to skid.
  - Main full and not drained: accepted data loads skid.
- Order is strictly FIFO. No entry is dropped or duplicated.
- flush:
  - Clears both valid bits next cycle.
  - Has priority over an input transfer in the same cycle; that input is discarded.
  - A drain in the flush cycle still counts as consumed.
- Reset mid-operation behaves as flush and also zeroes all data registers.

## Timing
- Reset values: out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, out_tag 0, skid_valid 0. in_ready is 0 while rst is high and 1 the cycle after.
- Latency: an input accepted at edge N is visible on out_* after edge N (cycle N+1), provided main was empty or draining.
- Throughput: 1 per cycle with out_ready held high.
- in_ready falls the cycle after a second entry is buffered. It rises the cycle after main drains with skid valid.
- out_* are stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: main is replaced, out_valid stays 1, in_ready stays 1.

## Test plan
- addi x1,x0,-1 (0xFFF00093), tag 0x100 -> next cycle out_imm 0xFFFFFFFF, fmt 1, illegal 0, tag 0x100. With DATA_WIDTH=64 -> 0xFFFFFFFFFFFFFFFF.
- beq x0,x0,-4 (0xFE000EE3) -> 0xFFFFFFFC fmt 3. jal x0,-8 (0xFF9FF06F) -> 0xFFFFFFF8 fmt 5. lui 0x12345037 -> 0x12345000 fmt 4.
- slli x1,x1,31 (0x01F09093) -> 0x0000001F fmt 6. srai x1,x1,3 (0x4030D093) -> 0x00000003 fmt 6, not 0x403.
- out_ready low, three back-to-back inputs A, B, C -> A in main, B in skid, in_ready 0 so C stalls. out_ready high -> A, B, C delivered in order, each exactly once.
- Both entries full, flush with in_valid high -> next cycle out_valid 0, in_ready 1, and the flush-cycle input never appears.
- Opcode 0x0000007F -> out_illegal 1, out_imm 0, fmt 0. Reset asserted mid-stream -> all outputs 0 the next cycle.
